wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two sources: the in-order pipeline writeback stage (already muxed between ALU, memory and CSR data) and the out-of-order long-latency multiply/divide unit (MDU).
- MDU results are buffered in a small FIFO. A fixed-priority arbiter with an anti-starvation counter selects one write per cycle.
- The register-file write is registered.

Parameters:
- XLEN, 64, data width of writeback values.
- REG_W, 5, destination register index width.
- FIFO_DEPTH, 2, MDU result buffer entries (power of two, ≥2).
- STARVE_MAX, 4, consecutive lost cycles after which the MDU FIFO is forced to win.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- pipe_valid  in  1  writeback stage has a register write this cycle.
- pipe_rd  in  REG_W  writeback destination register.
- pipe_data  in  XLEN  writeback value.
- pipe_ready  out  1  writeback accepted this cycle; pipeline stalls when low.
- mdu_valid  in  1  MDU result available.
- mdu_rd  in  REG_W  MDU destination register.
- mdu_data  in  XLEN  MDU result.
- mdu_ready  out  1  FIFO can accept an MDU result.
- rf_we  out  1  register-file write enable, registered.
- rf_waddr  out  REG_W  register-file write address, registered.
- rf_wdata  out  XLEN  register-file write data, registered.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, for hazard logic.

Behaviour:
- Reset (reset_n low, asynchronous):
  - FIFO empty, pointers 0, starve_cnt 0.
  - rf_we 0, rf_waddr 0, rf_wdata 0, fifo_count 0.
  - mdu_ready reads 1 and pipe_ready reads 1 after reset is released.
  - Reset mid-operation discards all buffered MDU results.
- MDU enqueue:
  - mdu_ready = (fifo_count != FIFO_DEPTH). It depends on state only, with no same-cycle dequeue bypass.
  - A transfer occurs when mdu_valid && mdu_ready. The entry {rd, data} is written at the tail and the tail advances, wrapping modulo FIFO_DEPTH.
  - No bypass from the MDU input to the write port. An enqueued entry is grant-eligible from the next cycle.
- Arbitration each cycle:
  - force = fifo nonempty && (starve_cnt == STARVE_MAX).
  - fifo_grant = fifo nonempty && (!pipe_valid || force).
  - pipe_ready = !force. It is combinational from state only, with no path from pipe_valid.
  - pipe_grant = pipe_valid && !force.
  - At most one grant per cycle.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) when the FIFO is nonempty && pipe_grant.
  - Clears to 0 on fifo_grant or when the FIFO is empty.
- Dequeue: on fifo_grant the head pops and the head pointer wraps modulo FIFO_DEPTH. Simultaneous enqueue and dequeue leaves fifo_count unchanged.
- Write port, next edge after a grant:
  - rf_we <= grant && (granted rd != 0); rf_waddr <= granted rd; rf_wdata <= granted data.
  - With no grant, rf_we <= 0; waddr and wdata hold.
  - A write to x0 is consumed (handshake completes, FIFO pops) but never asserts rf_we.
- Latency:
  - Pipe write accepted in cycle N gives rf_we in N+1.
  - MDU write enqueued in N is earliest at rf_we in N+2.
- Ordering: MDU results retire in FIFO order. Pipeline writes are never reordered among themselves.

Test Plan:
- After reset, pipe_valid=1, rd=5, data=0x1234 in cycle 1 → pipe_ready=1; cycle 2 rf_we=1, waddr=5, wdata=0x1234.
- Pipe idle; MDU pushes rd=7, data=0xDEAD in cycle 1 → fifo_count=1 in cycle 2, fifo_grant in 2; cycle 3 rf_we=1, waddr=7, wdata=0xDEAD; fifo_count=0.
- MDU pushes rd=3, then pipe_valid held high with distinct rds for 10 cycles:
  - Pipe wins 4 cycles (starve_cnt 1..4).
  - 5th cycle pipe_ready=0, FIFO wins, rf_waddr=3 the cycle after.
  - Pipe resumes next cycle and starve_cnt=0.
- MDU pushes 3 results back-to-back while pipe is busy → mdu_ready=0 after 2 entries; third is held until a pop; results retire in push order.
- Pipe writes rd=0, data=0xFF → pipe_ready=1 and handshake completes, but rf_we stays 0. The same holds for an MDU rd=0 entry, which still pops (fifo_count decrements).
- FIFO holds 2 entries when reset_n is pulsed low mid-cycle → rf_we, fifo_count and starve_cnt go to 0 immediately (asynchronously). After release, no stale write appears and mdu_ready=1.

Source files
------------

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the single register-file write port between the
//               in-order writeback stage and the out-of-order MDU.  MDU
//               results are buffered in a small FIFO.  A fixed-priority
//               arbiter favours the pipeline, and an anti-starvation counter
//               forces the FIFO head through after STARVE_MAX lost cycles.
//               The register-file write port is registered.
//
// Ports       :
//   clk        - clock, all state on the rising edge
//   reset_n    - asynchronous active-low reset
//   pipe_valid - writeback stage has a register write this cycle
//   pipe_rd    - writeback destination register
//   pipe_data  - writeback value
//   pipe_ready - writeback accepted this cycle (pipeline stalls when low)
//   mdu_valid  - MDU result available
//   mdu_rd     - MDU destination register
//   mdu_data   - MDU result
//   mdu_ready  - FIFO can accept an MDU result
//   rf_we      - register-file write enable (registered)
//   rf_waddr   - register-file write address (registered)
//   rf_wdata   - register-file write data (registered)
//   fifo_count - current FIFO occupancy, for hazard logic
//
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int XLEN       = 64,
    parameter int REG_W      = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,

    input  logic                          pipe_valid,
    input  logic [REG_W-1:0]              pipe_rd,
    input  logic [XLEN-1:0]               pipe_data,
    output logic                          pipe_ready,

    input  logic                          mdu_valid,
    input  logic [REG_W-1:0]              mdu_rd,
    input  logic [XLEN-1:0]               mdu_data,
    output logic                          mdu_ready,

    output logic                          rf_we,
    output logic [REG_W-1:0]              rf_waddr,
    output logic [XLEN-1:0]               rf_wdata,

    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_stv_w = $clog2(STARVE_MAX + 1);

    localparam logic [c_cnt_w-1:0] c_depth      = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one    = c_ptr_w'(1);
    localparam logic [c_stv_w-1:0] c_starve_max = c_stv_w'(STARVE_MAX);
    localparam logic [c_stv_w-1:0] c_stv_one    = c_stv_w'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [REG_W-1:0]   r_rd_mem   [FIFO_DEPTH];
    logic [XLEN-1:0]    r_data_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_cnt_w-1:0] r_count;
    logic [c_stv_w-1:0] r_starve;

    // ------------------------------------------------------------------------
    // Combinational arbitration
    // ------------------------------------------------------------------------
    logic               w_empty;
    logic               w_full;
    logic               w_force;
    logic               w_fifo_grant;
    logic               w_pipe_grant;
    logic               w_grant;
    logic               w_enq;
    logic               w_deq;
    logic [REG_W-1:0]   w_sel_rd;
    logic [XLEN-1:0]    w_sel_data;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_depth);

    // Forcing depends only on registered state, so pipe_ready never has a
    // combinational path from pipe_valid.
    assign w_force      = !w_empty && (r_starve == c_starve_max);
    assign w_fifo_grant = !w_empty && (!pipe_valid || w_force);
    assign w_pipe_grant = pipe_valid && !w_force;
    assign w_grant      = w_fifo_grant || w_pipe_grant;

    assign pipe_ready = !w_force;
    // No same-cycle dequeue bypass: a full FIFO refuses even if it pops now.
    assign mdu_ready  = !w_full;

    assign w_enq = mdu_valid && !w_full;
    assign w_deq = w_fifo_grant;

    // Grants are mutually exclusive, so the FIFO grant alone steers the mux.
    assign w_sel_rd   = w_fifo_grant ? r_rd_mem[r_head]   : pipe_rd;
    assign w_sel_data = w_fifo_grant ? r_data_mem[r_head] : pipe_data;

    assign fifo_count = r_count;

    // ------------------------------------------------------------------------
    // FIFO storage: no reset needed, validity is tracked by the pointers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_rd_mem[r_tail]   <= mdu_rd;
            r_data_mem[r_tail] <= mdu_data;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO pointers and occupancy (depth is a power of two, so the pointer
    // increment wraps naturally)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + c_ptr_one;
            end
            if (w_deq) begin
                r_head <= r_head + c_ptr_one;
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + c_cnt_one;
            end else if (!w_enq && w_deq) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Starvation counter: counts cycles the waiting FIFO head loses to the
    // pipeline, saturating at STARVE_MAX; any FIFO win or empty FIFO clears it.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve <= '0;
        end else if (w_empty || w_fifo_grant) begin
            r_starve <= '0;
        end else if (w_pipe_grant && (r_starve != c_starve_max)) begin
            r_starve <= r_starve + c_stv_one;
        end
    end

    // ------------------------------------------------------------------------
    // Registered register-file write port.  Writes to x0 complete their
    // handshake but never raise rf_we.  Address and data hold when idle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= w_grant && (w_sel_rd != '0);
            if (w_grant) begin
                rf_waddr <= w_sel_rd;
                rf_wdata <= w_sel_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Scoreboard bench for wb_port_arbiter.  Directed per-cycle
//               vectors carry hand-computed handshake values; expected
//               register-file writes are queued with their due cycle and a
//               monitor process compares them as the DUT presents writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    localparam int XLEN = 64;
    localparam int REG_W = 5;

    logic             clk;
    logic             reset_n;
    logic             pipe_valid;
    logic [REG_W-1:0] pipe_rd;
    logic [XLEN-1:0]  pipe_data;
    logic             pipe_ready;
    logic             mdu_valid;
    logic [REG_W-1:0] mdu_rd;
    logic [XLEN-1:0]  mdu_data;
    logic             mdu_ready;
    logic             rf_we;
    logic [REG_W-1:0] rf_waddr;
    logic [XLEN-1:0]  rf_wdata;
    logic [1:0]       fifo_count;

    wb_port_arbiter #(
        .XLEN(XLEN), .REG_W(REG_W), .FIFO_DEPTH(2), .STARVE_MAX(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .pipe_ready(pipe_ready),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .mdu_ready(mdu_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  data;
        int               due;
    } exp_t;

    exp_t exp_q[$];   // expected register-file writes, in retirement order
    exp_t mdu_q[$];   // bench model of MDU FIFO contents

    int n_pass  = 0;
    int n_total = 0;
    int cyc_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h",
                      name, cyc_cnt, act, expv);
    endtask

    // Monitor: compares each due expected write against the DUT write port.
    always @(negedge clk) begin
        if (reset_n) begin
            while (exp_q.size() > 0 && exp_q[0].due < cyc_cnt) begin
                n_total++;
                $display("FAIL missed_write @cycle %0d: got no write expected rd=%0d data=0x%0h",
                         cyc_cnt, exp_q[0].rd, exp_q[0].data);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc_cnt) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rf_we", {63'd0, rf_we}, 64'd1);
                chk("rf_waddr", {59'd0, rf_waddr}, {59'd0, e.rd});
                chk("rf_wdata", rf_wdata, e.data);
            end else if (rf_we) begin
                n_total++;
                $display("FAIL unexpected_write @cycle %0d: got rd=%0d data=0x%0h expected no write",
                         cyc_cnt, rf_waddr, rf_wdata);
            end
        end
    end

    // One clock cycle of stimulus.  Called just after a rising edge; drives
    // inputs, checks handshake outputs mid-cycle and updates the scoreboard.
    task automatic cyc(input logic pv, input logic [REG_W-1:0] prd,
                       input logic [XLEN-1:0] pd,
                       input logic mv, input logic [REG_W-1:0] mrd,
                       input logic [XLEN-1:0] md,
                       input logic epr, input logic emr, input int ecnt,
                       input logic fg);
        exp_t e;
        pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
        mdu_valid  = mv; mdu_rd  = mrd; mdu_data  = md;
        @(negedge clk);
        chk("pipe_ready", {63'd0, pipe_ready}, {63'd0, epr});
        chk("mdu_ready", {63'd0, mdu_ready}, {63'd0, emr});
        chk("fifo_count", {62'd0, fifo_count}, 64'(ecnt));
        if (fg) begin
            if (mdu_q.size() == 0) begin
                n_total++;
                $display("FAIL bench_model @cycle %0d: got empty model expected entry", cyc_cnt);
            end else begin
                e = mdu_q.pop_front();
                e.due = cyc_cnt + 1;
                if (e.rd != '0) exp_q.push_back(e);
            end
        end else if (pv && epr && prd != '0) begin
            e.rd = prd; e.data = pd; e.due = cyc_cnt + 1;
            exp_q.push_back(e);
        end
        if (mv && emr) begin
            e.rd = mrd; e.data = md; e.due = 0;
            mdu_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int ecnt, input logic emr, input logic fg);
        cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, emr, ecnt, fg);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
        mdu_valid  = 1'b0; mdu_rd  = '0; mdu_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state
        chk("reset_rf_we", {63'd0, rf_we}, 64'd0);
        chk("reset_rf_waddr", {59'd0, rf_waddr}, 64'd0);
        chk("reset_rf_wdata", rf_wdata, 64'd0);
        chk("reset_fifo_count", {62'd0, fifo_count}, 64'd0);
        chk("reset_mdu_ready", {63'd0, mdu_ready}, 64'd1);
        chk("reset_pipe_ready", {63'd0, pipe_ready}, 64'd1);

        // Pipe write: rf_we one cycle later
        cyc(1'b1, 5'd5, 64'h1234, 1'b0, '0, '0, 1'b1, 1'b1, 0, 1'b0);
        idle(0, 1'b1, 1'b0);

        // MDU write alone: grant-eligible next cycle, rf_we the one after
        cyc(1'b0, '0, '0, 1'b1, 5'd7, 64'hDEAD, 1'b1, 1'b1, 0, 1'b0);
        idle(1, 1'b1, 1'b1);
        idle(0, 1'b1, 1'b0);

        // Starvation: pipe wins four cycles, then the FIFO is forced through
        cyc(1'b0, '0, '0, 1'b1, 5'd3, 64'h3333, 1'b1, 1'b1, 0, 1'b0);
        cyc(1'b1, 5'd10, 64'h110, 1'b0, '0, '0, 1'b1, 1'b1, 1, 1'b0);
        cyc(1'b1, 5'd11, 64'h111, 1'b0, '0, '0, 1'b1, 1'b1, 1, 1'b0);
        cyc(1'b1, 5'd12, 64'h112, 1'b0, '0, '0, 1'b1, 1'b1, 1, 1'b0);
        cyc(1'b1, 5'd13, 64'h113, 1'b0, '0, '0, 1'b1, 1'b1, 1, 1'b0);
        cyc(1'b1, 5'd14, 64'h114, 1'b0, '0, '0, 1'b0, 1'b1, 1, 1'b1);
        for (int i = 14; i < 20; i++) begin
            cyc(1'b1, 5'(i), 64'(32'h100 + i), 1'b0, '0, '0, 1'b1, 1'b1, 0, 1'b0);
        end
        idle(0, 1'b1, 1'b0);

        // FIFO fills while pipe is busy; third MDU result waits for a pop
        cyc(1'b1, 5'd20, 64'h220, 1'b1, 5'd21, 64'hA1, 1'b1, 1'b1, 0, 1'b0);
        cyc(1'b1, 5'd22, 64'h222, 1'b1, 5'd23, 64'hA2, 1'b1, 1'b1, 1, 1'b0);
        cyc(1'b1, 5'd24, 64'h224, 1'b1, 5'd25, 64'hA3, 1'b1, 1'b0, 2, 1'b0);
        cyc(1'b1, 5'd26, 64'h226, 1'b1, 5'd25, 64'hA3, 1'b1, 1'b0, 2, 1'b0);
        cyc(1'b1, 5'd27, 64'h227, 1'b1, 5'd25, 64'hA3, 1'b1, 1'b0, 2, 1'b0);
        cyc(1'b1, 5'd28, 64'h228, 1'b1, 5'd25, 64'hA3, 1'b0, 1'b0, 2, 1'b1);
        cyc(1'b1, 5'd28, 64'h228, 1'b1, 5'd25, 64'hA3, 1'b1, 1'b1, 1, 1'b0);
        cyc(1'b1, 5'd29, 64'h229, 1'b0, '0, '0, 1'b1, 1'b0, 2, 1'b0);
        idle(2, 1'b0, 1'b1);
        idle(1, 1'b1, 1'b1);
        idle(0, 1'b1, 1'b0);

        // Writes to x0: handshakes complete, MDU entry pops, no rf_we
        cyc(1'b1, 5'd0, 64'hFF, 1'b0, '0, '0, 1'b1, 1'b1, 0, 1'b0);
        cyc(1'b0, '0, '0, 1'b1, 5'd0, 64'hEE, 1'b1, 1'b1, 0, 1'b0);
        idle(1, 1'b1, 1'b1);
        idle(0, 1'b1, 1'b0);
        idle(0, 1'b1, 1'b0);

        // Asynchronous reset with two buffered MDU results
        cyc(1'b1, 5'd1, 64'h501, 1'b1, 5'd2, 64'hB2, 1'b1, 1'b1, 0, 1'b0);
        cyc(1'b1, 5'd3, 64'h503, 1'b1, 5'd4, 64'hB4, 1'b1, 1'b1, 1, 1'b0);
        pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 64'h505;
        mdu_valid  = 1'b0;
        #1;
        chk("prereset_fifo_count", {62'd0, fifo_count}, 64'd2);
        chk("prereset_rf_we", {63'd0, rf_we}, 64'd1);
        chk("prereset_rf_waddr", {59'd0, rf_waddr}, 64'd3);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_rf_we", {63'd0, rf_we}, 64'd0);
        chk("async_rf_waddr", {59'd0, rf_waddr}, 64'd0);
        chk("async_rf_wdata", rf_wdata, 64'd0);
        chk("async_fifo_count", {62'd0, fifo_count}, 64'd0);
        exp_q.delete();
        mdu_q.delete();
        pipe_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(0, 1'b1, 1'b0);
        idle(0, 1'b1, 1'b0);
        idle(0, 1'b1, 1'b0);
        // After reset a single MDU push must retire normally
        cyc(1'b0, '0, '0, 1'b1, 5'd9, 64'hC9, 1'b1, 1'b1, 0, 1'b0);
        idle(1, 1'b1, 1'b1);
        idle(0, 1'b1, 1'b0);
        idle(0, 1'b1, 1'b0);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
